// File: rtl/load_byte_sequencer.sv
// Load byte sequencer: turns a byte/halfword/word load request into a series
// of single-byte reads on a byte-wide memory, assembles the bytes
// little-endian, and returns a sign- or zero-extended 32-bit result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid is held with its payload stable until that edge.
// The request side accepts only in IDLE, and the response side holds
// rsp_valid/rsp_data/rsp_err steady in RESP until rsp_ready is seen.
module load_byte_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_err;
    logic [31:0]       r_data;
    logic [1:0]        r_idx;

    logic              w_accept;
    logic              w_illegal;
    logic [1:0]        w_last_idx;
    logic [31:0]       w_ext;

    assign w_accept = req_valid & req_ready;

    // Misaligned halfword/word or the reserved size code never touch memory.
    assign w_illegal = (req_size == 2'b11) ||
                       ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Index of the final byte of the latched access (N-1).
    always_comb begin
        w_last_idx = 2'd0;
        case (r_size)
            SZ_HALF: w_last_idx = 2'd1;
            SZ_WORD: w_last_idx = 2'd3;
            default: w_last_idx = 2'd0;
        endcase
    end

    // Main sequencer: accept, issue one byte read, wait for its return, repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= 32'd0;
            r_idx    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_err    <= w_illegal;
                        r_data   <= 32'd0;
                        r_idx    <= 2'd0;
                        r_state  <= w_illegal ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Only one read is ever in flight, so the return always
                    // belongs to the byte at r_idx.
                    if (mem_rvalid) begin
                        case (r_idx)
                            2'd0:    r_data[7:0]   <= mem_rdata;
                            2'd1:    r_data[15:8]  <= mem_rdata;
                            2'd2:    r_data[23:16] <= mem_rdata;
                            default: r_data[31:24] <= mem_rdata;
                        endcase
                        r_idx   <= r_idx + 2'd1;
                        r_state <= (r_idx == w_last_idx) ? S_RESP : S_ISSUE;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Extend the assembled bytes according to the latched size and signedness.
    always_comb begin
        w_ext = r_data;
        case (r_size)
            SZ_BYTE: w_ext = {{24{r_signed & r_data[7]}}, r_data[7:0]};
            SZ_HALF: w_ext = {{16{r_signed & r_data[15]}}, r_data[15:0]};
            default: w_ext = r_data;
        endcase
    end

    // Outputs decode straight from state; req_ready is also held low while
    // reset is asserted so nothing can be accepted during reset.
    always_comb begin
        req_ready   = rst_n && (r_state == S_IDLE);
        mem_rd      = (r_state == S_ISSUE);
        mem_addr    = (r_state == S_ISSUE) ? (r_addr + ADDR_W'(r_idx)) : '0;
        rsp_valid   = (r_state == S_RESP);
        rsp_err     = (r_state == S_RESP) && r_err;
        rsp_data    = ((r_state == S_RESP) && !r_err) ? w_ext : 32'd0;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_load_byte_sequencer.sv
// Testbench for load_byte_sequencer: a byte memory responder with a
// per-read latency, a read-address monitor, and a response scoreboard.
module tb_load_byte_sequencer;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_rvalid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [1:0]        dbg_state;

    int num_checks = 0;
    int num_errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int ret_cnt = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [7:0]        mem_data_q[$];
    int                mem_dly_q[$];
    logic [32:0]       exp_q[$];

    load_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .o_dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] addr, input logic [1:0] size,
                                          input logic sgn, input logic [31:0] b);
        logic        err;
        logic [31:0] v;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
        case (size)
            2'b00:   v = {{24{sgn & b[7]}}, b[7:0]};
            2'b01:   v = {{16{sgn & b[15]}}, b[15:0]};
            default: v = b;
        endcase
        if (err) v = 32'd0;
        return {err, v};
    endfunction

    // Read monitor: address checks, single-outstanding check, idle address check
    initial begin
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            if (!mem_rd) begin
                check("mem_addr_idle", mem_addr, 0);
            end else begin
                check("rd_outstanding", rd_cnt - ret_cnt, 0);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_rd", mem_rd, 0);
                end else begin
                    a = exp_addr_q.pop_front();
                    check("mem_addr", mem_addr, a);
                end
                rd_cnt++;
            end
        end
    end

    // Memory responder: returns one byte per read after that read's latency
    initial begin
        int d;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(posedge clk);
            if (rd_cnt > ret_cnt) begin
                d = (mem_dly_q.size() > 0) ? mem_dly_q.pop_front() : 1;
                repeat (d - 1) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 8'hEE;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom_range(0, 255);
                ret_cnt++;
            end
        end
    end

    task automatic wait_accept(output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = $urandom_range(0, 3);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] bytes, input int dly, input int hold);
        logic [32:0] e;
        logic [31:0] held;
        int          n;
        int          lat_exp;
        int          acc_cyc;
        bit          ok;
        e = model(addr, size, sgn, bytes);
        exp_q.push_back(e);
        n = 1 << size;
        if (!e[32]) begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(addr + 32'(i));
                mem_data_q.push_back(bytes[8*i +: 8]);
                mem_dly_q.push_back(dly);
            end
        end
        lat_exp = (dly == 1 && hold == 0) ? (e[32] ? 1 : 2 * n + 1) : -1;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        rsp_ready  = (hold == 0);
        wait_accept(acc_cyc);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_seen", ok, 1);
        e = exp_q.pop_front();
        if (ok) begin
            if (lat_exp >= 0) check("latency", cyc - acc_cyc, lat_exp);
            if (hold > 0) begin
                held = rsp_data;
                for (int h = 0; h < hold; h++) begin
                    check("bp_valid", rsp_valid, 1);
                    check("bp_data", rsp_data, held);
                    check("bp_req_ready", req_ready, 0);
                    @(negedge clk);
                end
                #1;
                rsp_ready = 1'b1;
            end
            check("rsp_data", rsp_data, e[31:0]);
            check("rsp_err", rsp_err, e[32]);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rsp_drop", rsp_valid, 0);
            check("idle_ready", req_ready, 1);
        end
        check("reads_done", exp_addr_q.size(), 0);
        rsp_ready = 1'b1;
    endtask

    // Main stimulus
    initial begin
        int acc_cyc;
        int base_rd;
        bit ok;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        rsp_ready  = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
        check("state_after_rst", dbg_state, 0);

        do_load(32'h0000_0103, 2'b00, 1'b1, 32'h0000_0080, 1, 0);
        do_load(32'h0000_0200, 2'b01, 1'b0, 32'h0000_F234, 1, 0);
        do_load(32'h0000_0200, 2'b01, 1'b1, 32'h0000_F234, 1, 0);
        do_load(32'h0000_0010, 2'b10, 1'b0, 32'h1234_5678, 3, 0);
        do_load(32'h0000_0102, 2'b10, 1'b0, 32'h1234_5678, 1, 0);
        do_load(32'h0000_0101, 2'b01, 1'b1, 32'h0000_ABCD, 1, 0);
        do_load(32'h0000_0000, 2'b11, 1'b0, 32'h0000_00FF, 1, 0);
        do_load(32'h0000_0007, 2'b00, 1'b0, 32'h0000_009C, 1, 5);
        do_load(32'hFFFF_FFFC, 2'b10, 1'b1, 32'hC433_2211, 1, 0);
        do_load(32'h0000_0100, 2'b01, 1'b0, 32'h0000_8001, 2, 3);

        for (int k = 0; k < 20; k++) begin
            do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(1, 3), $urandom_range(0, 1) * 2);
        end

        // Reset while the third byte of a word load is in flight; its late
        // return must be ignored and no response may appear.
        base_rd = rd_cnt;
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h41);
        exp_addr_q.push_back(32'h42);
        mem_data_q.push_back(8'h01);
        mem_data_q.push_back(8'h02);
        mem_data_q.push_back(8'h03);
        mem_dly_q.push_back(1);
        mem_dly_q.push_back(1);
        mem_dly_q.push_back(6);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_addr   = 32'h40;
        req_size   = 2'b10;
        req_signed = 1'b0;
        rsp_ready  = 1'b1;
        wait_accept(acc_cyc);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            #1;
            if (rd_cnt - base_rd == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("third_rd_seen", ok, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_mem_rd", mem_rd, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        check("mid_rst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_rst", req_ready, 1);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("stale_rsp_valid", rsp_valid, 0);
            check("stale_state", dbg_state, 0);
        end
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rd_cnt == ret_cnt) begin
                ok = 1'b1;
                break;
            end
        end
        check("stale_return_done", ok, 1);
        do_load(32'h0000_0000, 2'b00, 1'b0, 32'h0000_005A, 1, 0);
        do_load(32'h0000_0000, 2'b00, 1'b1, 32'h0000_00C3, 1, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
